ad_frame_packer: RTL

Downstream stage for the AD sampling path: takes the conditioned ADC sample stream, decimates it to a UART-friendly rate, and buffers samples in a small FIFO. It serialises each buffered sample into a fixed byte frame for the team's byte-level UART transmitter, driving its send/done handshake. It sits between the sample averager and `uart_byte_tx`, replacing the free-running `send_en=1` hookup with framed, flow-controlled output.

---
 rtl/ad_pkg.sv | 33 +++
 rtl/ad_frame_packer_if.sv | 11 +
 rtl/ad_sample_fifo.sv | 45 ++++
 rtl/ad_frame_packer.sv | 96 +++++++++
 4 files changed

// File: rtl/ad_pkg.sv
// Shared types and constants for the AD frame packer.
// The frame length tracks AD_FRAME_CHECKSUM_EN (defined: 4-byte frames with checksum).
package ad_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT} ad_state_e;

  localparam logic [7:0] AD_HEADER = 8'hA5;
  localparam int unsigned IDX_W = 2;

`ifdef AD_FRAME_CHECKSUM_EN
  localparam int unsigned FRAME_LEN = 4;
`else
  localparam int unsigned FRAME_LEN = 3;
`endif

  // Byte idx of a frame carrying the zero-extended sample s16.
  function automatic logic [7:0] frame_byte(input logic [7:0] hdr, input logic [15:0] s16,
                                            input logic [IDX_W-1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = hdr;
      2'd1:    b = s16[15:8];
      2'd2:    b = s16[7:0];
`ifdef AD_FRAME_CHECKSUM_EN
      default: b = hdr + s16[15:8] + s16[7:0];
`else
      default: b = 8'h00;
`endif
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ad_frame_packer_if.sv
// Sample-in / UART-byte-out handshake bundle of the AD frame packer.
interface ad_frame_packer_if #(parameter int DATA_W = 12);
  logic [DATA_W-1:0] sample_in;
  logic              sample_valid;
  logic              tx_done;
  logic              send_en;
  logic [7:0]        data_byte;

  modport master (input sample_in, sample_valid, tx_done, output send_en, data_byte);
  modport slave  (output sample_in, sample_valid, tx_done, input send_en, data_byte);
endinterface

// File: rtl/ad_sample_fifo.sv
// Single-clock sample FIFO; push when full and pop when empty are ignored.
module ad_sample_fifo #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr;
  logic             do_push, do_pop;

  // Extra pointer bit distinguishes full from empty; level is their difference.
  assign level   = wptr - rptr;
  assign full    = level == (AW+1)'(DEPTH);
  assign empty   = level == '0;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      rdata <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) begin
        rptr  <= rptr + 1'b1;
        rdata <= mem[rptr[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/ad_frame_packer.sv
// Decimates the sample stream, buffers it and frames each sample for uart_byte_tx.
// AD_FRAME_CHECKSUM_EN appends a mod-256 checksum byte to each frame.
module ad_frame_packer import ad_pkg::*; #(
  parameter  int         DATA_W     = 12,
  parameter  int         FIFO_DEPTH = 16,
  parameter  int         DECIM      = 1000,
  parameter  logic [7:0] HEADER     = AD_HEADER,
  localparam int         LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  ad_frame_packer_if.master bus,
  output logic              overflow,
  output logic [LVL_W-1:0]  fifo_level
);
  localparam int DCW = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [DCW-1:0]   dcnt;
  logic             dec_hit, full, empty, pop, last;
  logic [15:0]      rdata, frame;
  logic [IDX_W-1:0] idx;
  logic [7:0]       data_byte;
  ad_state_e        state, state_nxt;

  assign dec_hit = bus.sample_valid && (dcnt == DCW'(DECIM - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt     <= '0;
      overflow <= 1'b0;
    end else begin
      if (bus.sample_valid) dcnt <= dec_hit ? '0 : dcnt + 1'b1;
      // FIFO full status is pre-pop, so a same-cycle pop never rescues this sample.
      if (dec_hit && full) overflow <= 1'b1;
    end
  end

  ad_sample_fifo #(.WIDTH(16), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (dec_hit),
    .wdata (16'(bus.sample_in[DATA_W-1:0])),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .level (fifo_level),
    .rdata (rdata)
  );

  assign last = idx == IDX_W'(FRAME_LEN - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        pop       = 1'b1;
        state_nxt = LOAD;
      end
      LOAD: state_nxt = SEND;
      SEND: state_nxt = WAIT;
      WAIT: if (bus.tx_done) state_nxt = last ? IDLE : SEND;
      default: state_nxt = IDLE;
    endcase
  end

  // LOAD absorbs the FIFO read latency; data_byte only changes on the way into SEND.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame     <= '0;
      idx       <= '0;
      data_byte <= '0;
    end else begin
      case (state)
        LOAD: begin
          frame     <= rdata;
          idx       <= '0;
          data_byte <= HEADER;
        end
        WAIT: if (bus.tx_done && !last) begin
          idx       <= idx + 1'b1;
          data_byte <= frame_byte(HEADER, frame, idx + 1'b1);
        end
        default: ;
      endcase
    end
  end

  assign bus.send_en   = state == SEND;
  assign bus.data_byte = data_byte;
endmodule
